// File: rtl/imm_gen.sv
// RV32I immediate generator: registered I/S/B/U/J/CSR-zimm decode with valid flag.
// Optional IMMGEN_ILLEGAL_CHK_EN registers an illegal-format flag on imm_err.
module imm_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inst,
  input  logic [2:0]  immsrc,
  output logic [31:0] immext,
  output logic        out_valid,
  output logic        imm_err
);

  logic [31:0] immext_d;
  logic [31:0] immext_q;
  logic        out_valid_q;
  logic        sgn;

  // Opcode bits are never part of any immediate.
  logic        unused_opcode;
  assign unused_opcode = ^inst[6:0];

  assign sgn = inst[31];

  always_comb begin
    immext_d = '0;
    case (immsrc)
      3'b000: immext_d = {{20{sgn}}, inst[31:20]};
      3'b001: immext_d = {{20{sgn}}, inst[31:25],
                          inst[11:7]};
      3'b010: immext_d = {inst[31:12], 12'b0};
      3'b011: immext_d = {{12{sgn}}, inst[19:12],
                          inst[20], inst[30:21], 1'b0};
      3'b100: immext_d = {27'b0, inst[19:15]};
      3'b101: immext_d = {{20{sgn}}, inst[7],
                          inst[30:25], inst[11:8], 1'b0};
      default: immext_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      immext_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) immext_q <= immext_d;
    end
  end

  assign immext    = immext_q;
  assign out_valid = out_valid_q;

`ifdef IMMGEN_ILLEGAL_CHK_EN
  logic imm_err_d;
  logic imm_err_q;

  assign imm_err_d = immsrc[2] & immsrc[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_err_q <= 1'b0;
    end else if (in_valid) begin
      imm_err_q <= imm_err_d;
    end
  end

  assign imm_err = imm_err_q;
`else
  assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Directed scoreboard bench for imm_gen.
// Expected results are queued at drive time and popped one cycle later.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic [2:0]  immsrc = '0;
  logic [31:0] immext;
  logic        out_valid;
  logic        imm_err;

  imm_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inst      (inst),
    .immsrc    (immsrc),
    .immext    (immext),
    .out_valid (out_valid),
    .imm_err   (imm_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] imm;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  logic [31:0] last_imm = '0;
  logic        last_err = 1'b0;

`ifdef IMMGEN_ILLEGAL_CHK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h",
                tag, obs, exp);
  endtask

  // One accepted input; its result is checked after the next edge.
  task automatic drive(input string tag,
                       input logic [31:0] i,
                       input logic [2:0] src,
                       input logic [31:0] exp_imm,
                       input logic exp_err);
    exp_t e;
    @(negedge clk);
    inst     = i;
    immsrc   = src;
    in_valid = 1'b1;
    sb.push_back('{imm: exp_imm, err: exp_err});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_imm"}, immext, e.imm);
      chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_err"}, {31'b0, imm_err},
          {31'b0, e.err});
      last_imm = e.imm;
      last_err = e.err;
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    inst     = 32'hDEAD_BEEF;
    immsrc   = 3'b000;
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_imm"}, immext, last_imm);
    chk({tag, "_err"}, {31'b0, imm_err},
        {31'b0, last_err});
  endtask

  initial begin
    #1;
    chk("rst_imm", immext, 32'd0);
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_err", {31'b0, imm_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    drive("i_pos", 32'h0030_0293, 3'b000,
          32'h0000_0003, 1'b0);
    drive("i_neg", 32'hFFF0_0293, 3'b000,
          32'hFFFF_FFFF, 1'b0);
    drive("s_pos", 32'h0141_2223, 3'b001,
          32'h0000_0004, 1'b0);
    drive("s_neg", 32'hFE51_2E23, 3'b001,
          32'hFFFF_FFFC, 1'b0);
    drive("b_neg", 32'hFE61_0AE3, 3'b101,
          32'hFFFF_FFF4, 1'b0);
    drive("b_pos", 32'h0062_8863, 3'b101,
          32'h0000_0010, 1'b0);
    drive("u", 32'h1234_50B7, 3'b010,
          32'h1234_5000, 1'b0);
    drive("j_pos", 32'h1F40_00EF, 3'b011,
          32'h0000_01F4, 1'b0);
    drive("j_neg", 32'h8000_00EF, 3'b011,
          32'hFFF0_0000, 1'b0);
    drive("z", 32'h000F_D073, 3'b100,
          32'h0000_001F, 1'b0);
    drive("ill110", 32'hFFFF_FFFF, 3'b110,
          32'h0000_0000, ERR_ON);
    drive("ill111", 32'h8000_0000, 3'b111,
          32'h0000_0000, ERR_ON);
    drive("z_after", 32'h000F_D073, 3'b100,
          32'h0000_001F, 1'b0);
    drive("ill_hold", 32'h1234_5678, 3'b110,
          32'h0000_0000, ERR_ON);

    repeat (3) idle("idle");

    drive("i_neg2", 32'hFFF0_0293, 3'b000,
          32'hFFFF_FFFF, 1'b0);

    // Mid-cycle asynchronous reset with a pending input.
    @(negedge clk);
    inst     = 32'h1234_50B7;
    immsrc   = 3'b010;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_imm", immext, 32'd0);
    chk("arst_vld", {31'b0, out_valid}, 32'd0);
    chk("arst_err", {31'b0, imm_err}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstwin_vld", {31'b0, out_valid}, 32'd0);
    chk("rstwin_imm", immext, 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    last_imm = '0;
    last_err = 1'b0;
    idle("post_rst");

    drive("first", 32'h0141_2223, 3'b001,
          32'h0000_0004, 1'b0);
    idle("tail");

    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
# imm_gen

Immediate generator for the RV32I core. It decodes the immediate field of a 32-bit instruction into a 32-bit extended operand, using the format selected by the control unit's `immsrc` code. The output is registered with one cycle of latency and an accompanying valid flag. It sits between instruction fetch/decode and the ALU operand mux and branch/jump target adder.

## Interface
Parameters: none.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `in_valid`  in  1  — `inst`/`immsrc` valid this cycle.
- `inst`  in  32  — raw instruction word.
- `immsrc`  in  3  — immediate format select.
- `immext`  out  32  — extended immediate, signed two's complement, registered.
- `out_valid`  out  1  — `immext` holds the result of an accepted input.
- `imm_err`  out  1  — last accepted `immsrc` was illegal (only with `IMMGEN_ILLEGAL_CHK_EN`; otherwise tied 0).

## Operation
Format decode (`s` = `inst[31]` replicated to fill the upper bits):
- `000` I: {s, `inst[31:20]`}.
- `001` S: {s, `inst[31:25]`, `inst[11:7]`}.
- `010` U: {`inst[31:12]`, 12'b0}; no extension.
- `011` J: {s, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 1'b0}; 21-bit immediate, bit 0 always 0.
- `100` Z (CSR zimm): {27'b0, `inst[19:15]`}; zero-extended.
- `101` B: {s, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 1'b0}; 13-bit immediate, bit 0 always 0.
- `110`, `111`: illegal. `immext` = 0.
- Decode is purely bit-select/extension. There is no arithmetic and no dependence on the opcode field.
- When `in_valid` = 0, `immext` and `imm_err` hold their previous values and `out_valid` goes to 0.

## Timing
- Latency is one cycle. Inputs sampled at edge N with `in_valid` = 1 appear on `immext` with `out_valid` = 1 after edge N.
- Throughput is one result per cycle. There is no backpressure and no stall input.
- Reset (asynchronous, any time, including mid-stream): `immext` = 0x00000000, `out_valid` = 0, `imm_err` = 0 immediately. The first valid output follows the first accepted input after `rst` deasserts.
- Back-to-back inputs with different `immsrc` values each produce their own result on consecutive cycles.
- If `in_valid` = 1 and `rst` = 1 on the same edge, reset wins and the input is dropped.

## Configuration
- `IMMGEN_ILLEGAL_CHK_EN` defined:
  - `imm_err` is registered alongside `immext`.
  - It is 1 for an accepted input with `immsrc` ∈ {110, 111} and 0 for any other accepted input.
  - It holds when `in_valid` = 0 and resets to 0.
- Not defined: `imm_err` is constant 0.
- In both cases, illegal codes produce `immext` = 0.

## Test plan
- I-type: `inst` = 0x00300293 (addi x5,x0,3), `immsrc` = 000 -> `immext` = 0x00000003 one cycle later, `out_valid` = 1. Also `inst` = 0xFFF00293 -> 0xFFFFFFFF.
- S-type: `inst` = 0x01412223, `immsrc` = 001 -> 0x00000004. Also `inst` = 0xFE512E23 (sw x5,-4(x2)) -> 0xFFFFFFFC.
- B-type: `inst` = 0xFE610AE3, `immsrc` = 101 -> 0xFFFFFFF4. Also `inst` = 0x00628863 (beq x5,x6,16) -> 0x00000010.
- U/J: `inst` = 0x123450B7, `immsrc` = 010 -> 0x12345000. Then `inst` = 0x1F4000EF, `immsrc` = 011 -> 0x000001F4, with the two results on consecutive cycles. Also `inst` = 0x800000EF, `immsrc` = 011 -> 0xFFF00000.
- Z/illegal: `inst` = 0x000FD073, `immsrc` = 100 -> 0x0000001F. `immsrc` = 110 -> `immext` = 0, `imm_err` = 1 (with macro) or 0 (without).
- Control: assert `rst` mid-stream -> all outputs 0 immediately. `in_valid` = 0 for 3 cycles -> `out_valid` = 0 and `immext` unchanged.
